// File: rtl/gpr_wb_sched.sv
// GPR write-back scheduler: init sweep R[i]=i, then a PERIOD-cycle frame with one round-robin write slot.
// Latency 1 cycle accept->gpr_we; requesters are held off (ready low) outside WR_PHASE and while not granted.
module gpr_wb_sched #(
  parameter int PERIOD       = 6,
  parameter int RD_PHASE     = 2,
  parameter int WR_PHASE     = 5,
  parameter bit INIT_EN      = 1'b1,
  parameter bit ZERO_PROTECT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [4:0]  req0_addr,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [4:0]  req1_addr,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  output logic        gpr_we,
  output logic [4:0]  gpr_wa,
  output logic [31:0] gpr_wd,
  output logic        rd_strobe,
  output logic [2:0]  phase,
  output logic        init_done
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  localparam logic [2:0] RD_P   = 3'(RD_PHASE);
  localparam logic [2:0] WR_P   = 3'(WR_PHASE);
  localparam logic [2:0] LAST_P = 3'(PERIOD - 1);

  state_t      state, state_nxt;
  logic [4:0]  idx;
  logic        last_grant;
  logic        grant;
  logic        xfer;
  logic [4:0]  win_addr;
  logic [31:0] win_data;

  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rd_strobe  = 1'b0;
    case (state)
      S_INIT: if (idx == 5'd31) state_nxt = S_RUN;
      S_RUN: begin
        rd_strobe = (phase == RD_P);
        if (req0_valid && req1_valid) grant = ~last_grant;
        else                          grant = req1_valid;
        // ready is masked during reset so an aborted cycle never looks like a handshake
        if (phase == WR_P && !reset) begin
          req0_ready = req0_valid && !grant;
          req1_ready = req1_valid && grant;
        end
      end
      default: state_nxt = S_INIT;
    endcase
    xfer     = req0_ready || req1_ready;
    win_addr = grant ? req1_addr : req0_addr;
    win_data = grant ? req1_data : req0_data;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= INIT_EN ? S_INIT : S_RUN;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx        <= 5'd0;
      phase      <= 3'd0;
      last_grant <= 1'b1;
      gpr_we     <= 1'b0;
      gpr_wa     <= 5'd0;
      gpr_wd     <= 32'd0;
      init_done  <= !INIT_EN;
    end else if (state == S_INIT) begin
      gpr_we <= 1'b1;
      gpr_wa <= idx;
      gpr_wd <= {27'b0, idx};
      idx    <= idx + 5'd1;
      phase  <= 3'd0;
      if (idx == 5'd31) init_done <= 1'b1;
    end else begin
      phase  <= (phase == LAST_P) ? 3'd0 : phase + 3'd1;
      gpr_we <= 1'b0;
      if (xfer) begin
        last_grant <= grant;
        // R0 is hard-wired: the handshake completes but nothing is written
        if (!(ZERO_PROTECT && win_addr == 5'd0)) begin
          gpr_we <= 1'b1;
          gpr_wa <= win_addr;
          gpr_wd <= win_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_gpr_wb_sched.sv
// Randomized bench for gpr_wb_sched: frame/arbitration reference model feeding a write scoreboard.
module tb_gpr_wb_sched;

  localparam int PERIOD = 6;
  localparam int RD     = 2;
  localparam int WR     = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [4:0]  req0_addr = '0, req1_addr = '0;
  logic [31:0] req0_data = '0, req1_data = '0;
  logic        req0_ready, req1_ready;
  logic        gpr_we;
  logic [4:0]  gpr_wa;
  logic [31:0] gpr_wd;
  logic        rd_strobe;
  logic [2:0]  phase;
  logic        init_done;

  gpr_wb_sched #(
    .PERIOD(PERIOD), .RD_PHASE(RD), .WR_PHASE(WR), .INIT_EN(1'b1), .ZERO_PROTECT(1'b1)
  ) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .gpr_we(gpr_we), .gpr_wa(gpr_wa), .gpr_wd(gpr_wd),
    .rd_strobe(rd_strobe), .phase(phase), .init_done(init_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  // Reference model: init countdown, frame phase, last winner, pending requests
  int          init_left = 0;
  int          m_phase   = 0;
  int          m_last    = 1;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [4:0]  a0 = '0, a1 = '0;
  logic [31:0] d0 = '0, d1 = '0;
  logic        rst_edge;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Write monitor: every gpr_we pulse must match the oldest predicted write
  initial begin
    wr_t e;
    forever begin
      @(posedge clk);
      rst_edge = reset;
      #1;
      if (rst_edge) begin
        chk("rst_we", gpr_we, 0);
        chk("rst_wa", gpr_wa, 0);
        chk("rst_wd", gpr_wd, 0);
        chk("rst_phase", phase, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_rd_strobe", rd_strobe, 0);
      end else if (gpr_we) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", gpr_wa, e.a);
          chk("wr_data", gpr_wd, e.d);
        end
      end
    end
  end

  task automatic drive();
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
  endtask

  // Entered and left on a falling edge; reset released at the exit edge.
  task automatic do_reset(input int n, input bit keep);
    wr_t e;
    reset = 1'b1;
    exp_q.delete();
    if (!keep) begin v0 = 1'b0; v1 = 1'b0; end
    drive();
    #1;
    chk("rst_hold_ready0", req0_ready, 0);
    chk("rst_hold_ready1", req1_ready, 0);
    repeat (n) @(negedge clk);
    reset     = 1'b0;
    init_left = 32;
    m_phase   = 0;
    m_last    = 1;
    for (int i = 0; i < 32; i++) begin
      e.a = 5'(i);
      e.d = 32'(i);
      exp_q.push_back(e);
    end
  endtask

  // One clock: optionally raise new requests, drive, predict and check the comb outputs.
  task automatic cycle(input int p0, input int p1);
    bit  acc0, acc1;
    int  w;
    wr_t e;
    if (!v0 && $urandom_range(99) < p0) begin v0 = 1'b1; a0 = 5'($urandom_range(31)); d0 = $urandom; end
    if (!v1 && $urandom_range(99) < p1) begin v1 = 1'b1; a1 = 5'($urandom_range(31)); d1 = $urandom; end
    drive();
    #1;
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (init_left > 0) begin
      chk("init_phase", phase, 0);
      chk("init_done_low", init_done, 0);
      chk("init_rd_strobe", rd_strobe, 0);
      chk("init_ready0", req0_ready, 0);
      chk("init_ready1", req1_ready, 0);
      init_left--;
    end else begin
      chk("run_phase", phase, m_phase);
      chk("run_init_done", init_done, 1);
      chk("rd_strobe", rd_strobe, (m_phase == RD));
      if (m_phase == WR && (v0 || v1)) begin
        w      = (v0 && v1) ? 1 - m_last : (v1 ? 1 : 0);
        acc0   = (w == 0);
        acc1   = (w == 1);
        m_last = w;
        e.a    = (w == 0) ? a0 : a1;
        e.d    = (w == 0) ? d0 : d1;
        if (e.a != 5'd0) exp_q.push_back(e);
      end
      chk("ready0", req0_ready, acc0);
      chk("ready1", req1_ready, acc1);
      m_phase = (m_phase + 1) % PERIOD;
    end
    if (acc0) v0 = 1'b0;
    if (acc1) v1 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    do_reset(2, 1'b0);

    // init sweep then idle
    repeat (40) cycle(0, 0);

    // single ALU write-back raised at phase 0
    for (int i = 0; i < PERIOD && m_phase != 0; i++) cycle(0, 0);
    v0 = 1'b1; a0 = 5'd5; d0 = 32'hDEADBEEF;
    repeat (12) cycle(0, 0);

    // both requesters saturated for four frames
    repeat (4 * PERIOD) cycle(100, 100);
    repeat (2 * PERIOD) cycle(0, 0);

    // write to R0 completes the handshake but never writes
    v1 = 1'b1; a1 = 5'd0; d1 = 32'h1234;
    repeat (2 * PERIOD) cycle(0, 0);

    // idle frames
    repeat (30) cycle(0, 0);

    // random traffic
    repeat (600) cycle(30, 30);
    repeat (2 * PERIOD) cycle(0, 0);

    // reset at init idx=10
    do_reset(1, 1'b0);
    repeat (10) cycle(0, 0);
    do_reset(1, 1'b0);
    repeat (40) cycle(0, 0);

    // reset at RUN phase WR with req0 pending; req0 must win first afterwards
    for (int i = 0; i < PERIOD && m_phase != WR; i++) cycle(0, 0);
    v0 = 1'b1; a0 = 5'd7; d0 = 32'hCAFE0007;
    do_reset(1, 1'b1);
    v1 = 1'b1; a1 = 5'd9; d1 = 32'hBEEF0009;
    repeat (32 + 3 * PERIOD) cycle(0, 0);

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
